imm_gen_pipe: RTL

//   Pipelined, parametrised RV immediate generator; successor to the combinational imm_gen.

---
 rtl/imm_gen_pipe_if.sv | 44 ++++
 rtl/imm_gen_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode and execute for the pipelined immediate generator.
// IMM_GEN_ILLEGAL_EN adds the illegal_out signal to the output side.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic [2:0]      fmt_out;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            illegal_out;
`endif

    // Producer of instructions / consumer of immediates
    modport master (
        output in_valid,
        output inst_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  imm_out,
`ifdef IMM_GEN_ILLEGAL_EN
        input  illegal_out,
`endif
        input  fmt_out
    );

    // Immediate generator side
    modport slave (
        input  in_valid,
        input  inst_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output imm_out,
`ifdef IMM_GEN_ILLEGAL_EN
        output illegal_out,
`endif
        output fmt_out
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes I/S/B/U/J/SHAMT immediates into a
// valid/ready pipeline of PIPE_DEPTH stages with flush.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (adds a pipelined illegal_out flag).
module imm_gen_pipe #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    imm_gen_pipe_if.slave bus
);
    localparam int unsigned LAST = PIPE_DEPTH - 1;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
`ifdef IMM_GEN_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    logic [31:0]     inst;
    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh;
    entry_t          dec;

    entry_t data_q [PIPE_DEPTH];
    logic   vld_q  [PIPE_DEPTH];
    logic   load   [PIPE_DEPTH];
    logic   accept;

    assign inst   = bus.inst_in;
    assign opc    = inst[6:0];
    assign funct3 = inst[14:12];

    // Candidate immediates, built at 64 bits and trimmed to XLEN
    assign imm_i  = XLEN'({{52{inst[31]}}, inst[31:20]});
    assign imm_s  = XLEN'({{52{inst[31]}}, inst[31:25], inst[11:7]});
    assign imm_b  = XLEN'({{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    assign imm_u  = XLEN'({{32{inst[31]}}, inst[31:12], 12'b0});
    assign imm_j  = XLEN'({{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    assign imm_sh = (XLEN == 64) ? XLEN'({58'b0, inst[25:20]}) : XLEN'({59'b0, inst[24:20]});

    // Opcode decode into format code and immediate
    always_comb begin
        dec     = '0;
        dec.fmt = FMT_NONE;
        dec.imm = '0;
        case (opc)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = imm_sh;
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
            end
            7'b0000011, 7'b1100111, 7'b0011011: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = imm_j;
            end
            default: begin
                dec.fmt = FMT_NONE;
                dec.imm = '0;
            end
        endcase
`ifdef IMM_GEN_ILLEGAL_EN
        dec.illegal = (dec.fmt == FMT_NONE);
`endif
    end

    // Ready ripples back from the consumer: a stage can load if empty or its occupant leaves
    always_comb begin
        logic down;
        down = bus.out_ready;
        for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
            load[k] = 1'b0;
        end
        for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
            load[k] = ~vld_q[k] | down;
            down    = load[k];
        end
    end

    assign bus.in_ready = ~flush & load[0];
    assign accept       = bus.in_valid & bus.in_ready;

    // Stage registers: reset clears everything, flush clears only valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                vld_q[k]  <= 1'b0;
                data_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                vld_q[k] <= 1'b0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0] <= accept;
                if (accept) begin
                    data_q[0] <= dec;
                end
            end
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    assign bus.out_valid = vld_q[LAST];
    assign bus.imm_out   = data_q[LAST].imm;
    assign bus.fmt_out   = data_q[LAST].fmt;
`ifdef IMM_GEN_ILLEGAL_EN
    assign bus.illegal_out = data_q[LAST].illegal;
`endif

endmodule
